mac_row_ws_os: RTL

- Parametrised next-generation systolic MAC row. It supports weight-stationary (WS) and output-stationary (OS) dataflow, selected at run time.
- Activations and instruction tokens move west to east, one tile per cycle.
- In WS mode, partial sums flow north to south. In OS mode, each tile holds its own accumulator and emits it when a drain token passes.
- The row sits between the L0/IFIFO feed and the OFIFO/psum path of the core. Instances are stacked by the array wrapper.

---
 rtl/mac_row_ws_os_pkg.sv | 23 ++
 rtl/mac_row_ws_os_tile.sv | 143 ++++++++++++++
 rtl/mac_row_ws_os.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/mac_row_ws_os_pkg.sv
// -----------------------------------------------------------------------------
// mac_pkg
// Shared definitions for the weight-/output-stationary systolic MAC row:
// dataflow mode encodings, instruction bit positions and the row FSM states.
// -----------------------------------------------------------------------------
package mac_pkg;

  // Dataflow selection carried in mode / mode_q
  localparam logic MODE_WS = 1'b0;
  localparam logic MODE_OS = 1'b1;

  // Instruction token bit positions
  localparam int INST_EXEC = 1;  // execute (WS) / accumulate (OS)
  localparam int INST_LOAD = 0;  // kernel load (WS) / accumulator clear (OS)

  // Row control FSM
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

endpackage

// File: rtl/mac_row_ws_os_tile.sv
// -----------------------------------------------------------------------------
// mac_tile_ws_os
// One tile of the MAC row. Holds a stationary weight with its load_done flag
// (WS), a local accumulator (OS), the registered psum/result output and the
// registered east copies of the activation, sign mode, instruction and drain.
//
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   mode_q                current dataflow (MODE_WS / MODE_OS)
//   mode_clr              mode_q is changing this edge: drop load_done and acc
//   act_w, act_sgn_w      activation from the west and its signedness
//   inst_w, drain_w       instruction / drain token from the west
//   in_n                  WS: psum from the north; OS: weight in bits [bw-1:0]
//   act_e .. drain_e      registered copies forwarded to the east neighbour
//   out_s, valid          registered psum/result and its one-cycle strobe
// -----------------------------------------------------------------------------
module mac_tile_ws_os
  import mac_pkg::*;
#(
  parameter int bw      = 4,
  parameter int psum_bw = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               mode_q,
  input  logic               mode_clr,
  input  logic [bw-1:0]      act_w,
  input  logic               act_sgn_w,
  input  logic [1:0]         inst_w,
  input  logic               drain_w,
  input  logic [psum_bw-1:0] in_n,
  output logic [bw-1:0]      act_e,
  output logic               act_sgn_e,
  output logic [1:0]         inst_e,
  output logic               drain_e,
  output logic [psum_bw-1:0] out_s,
  output logic               valid
);

  logic [bw-1:0]             weight_r;
  logic                      load_done_r;
  logic [psum_bw-1:0]        acc_r;

  logic [bw-1:0]             w_sel_s;
  logic signed [psum_bw-1:0] act_ext_s;
  logic signed [psum_bw-1:0] w_ext_s;
  logic signed [psum_bw-1:0] product_s;
  logic [psum_bw-1:0]        acc_nxt_s;
  logic                      load_hit_s;
  logic                      exec_s;

  // Operand selection, extended product and next accumulator value
  always_comb begin
    w_sel_s    = weight_r;
    act_ext_s  = '0;
    acc_nxt_s  = acc_r;
    // OS weights stream in from the north; WS uses the stationary register
    if (mode_q == MODE_OS) begin
      w_sel_s = in_n[bw-1:0];
    end else begin
      w_sel_s = weight_r;
    end
    if (act_sgn_w) begin
      act_ext_s = {{(psum_bw-bw){act_w[bw-1]}}, act_w};
    end else begin
      act_ext_s = {{(psum_bw-bw){1'b0}}, act_w};
    end
    w_ext_s    = {{(psum_bw-bw){w_sel_s[bw-1]}}, w_sel_s};
    // Truncated product of the extended operands wraps modulo 2^psum_bw
    product_s  = act_ext_s * w_ext_s;
    load_hit_s = inst_w[INST_LOAD] && !load_done_r;
    exec_s     = inst_w[INST_EXEC];
    case (inst_w)
      2'b01:   acc_nxt_s = '0;
      2'b10:   acc_nxt_s = acc_r + product_s;
      2'b11:   acc_nxt_s = product_s;
      default: acc_nxt_s = acc_r;
    endcase
  end

  // Tile state, registered outputs and east forwarding
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      weight_r    <= '0;
      load_done_r <= 1'b0;
      acc_r       <= '0;
      act_e       <= '0;
      act_sgn_e   <= 1'b0;
      inst_e      <= 2'b00;
      drain_e     <= 1'b0;
      out_s       <= '0;
      valid       <= 1'b0;
    end else begin
      act_e     <= act_w;
      act_sgn_e <= act_sgn_w;
      drain_e   <= drain_w;
      if (mode_q == MODE_WS) begin
        // The first unloaded tile consumes the load bit so beat k lands in tile k
        if (load_hit_s) begin
          weight_r <= act_w;
          inst_e   <= {inst_w[INST_EXEC], 1'b0};
        end else begin
          inst_e   <= inst_w;
        end
        if (exec_s) begin
          out_s <= in_n + product_s;
          valid <= 1'b1;
        end else begin
          valid <= 1'b0;
        end
        // Execute re-arms the tile for the next load round
        if (mode_clr || exec_s) begin
          load_done_r <= 1'b0;
        end else if (load_hit_s) begin
          load_done_r <= 1'b1;
        end else begin
          load_done_r <= load_done_r;
        end
        if (mode_clr) begin
          acc_r <= '0;
        end else begin
          acc_r <= acc_r;
        end
      end else begin
        inst_e <= inst_w;
        if (mode_clr) begin
          load_done_r <= 1'b0;
          acc_r       <= '0;
          valid       <= 1'b0;
        end else if (drain_w) begin
          // Drain reports the value including any same-edge accumulate
          out_s <= acc_nxt_s;
          valid <= 1'b1;
          acc_r <= '0;
        end else begin
          acc_r <= acc_nxt_s;
          valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/mac_row_ws_os.sv
// -----------------------------------------------------------------------------
// mac_row_ws_os
// Systolic MAC row with run-time weight-stationary / output-stationary
// dataflow. Activations and tokens ripple west to east one tile per cycle;
// the top holds the latched mode, the IDLE/RUN/DRAIN control FSM and busy.
//
// Ports:
//   clk, reset   clock, asynchronous active-high reset
//   mode         requested dataflow, adopted as mode_q only when fully quiet
//   act_mode     activation signedness (weights are always signed)
//   in_w         activation entering tile 0
//   inst_w       bit1 execute/accumulate, bit0 load/clear
//   drain        OS drain token into tile 0 (ignored in WS)
//   in_n         per-slice psum in (WS) or skewed weight (OS)
//   out_s, valid per-slice psum/result and update strobe
//   busy         tokens in flight or the row is draining
// -----------------------------------------------------------------------------
module mac_row_ws_os
  import mac_pkg::*;
#(
  parameter int bw      = 4,
  parameter int psum_bw = 16,
  parameter int col     = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   mode,
  input  logic                   act_mode,
  input  logic [bw-1:0]          in_w,
  input  logic [1:0]             inst_w,
  input  logic                   drain,
  input  logic [psum_bw*col-1:0] in_n,
  output logic [psum_bw*col-1:0] out_s,
  output logic [col-1:0]         valid,
  output logic                   busy
);

  localparam int CNT_W = $clog2(col);

  // Index j is the input of tile j; index col is the east end of the row
  logic [col:0][bw-1:0] act_pipe_s;
  logic [col:0]         sgn_pipe_s;
  logic [col:0][1:0]    inst_pipe_s;
  logic [col:0]         drain_pipe_s;

  state_e               state_r;
  state_e               state_nxt_s;
  logic [CNT_W-1:0]     cnt_r;
  logic [CNT_W-1:0]     cnt_nxt_s;
  logic                 busy_r;
  logic                 mode_q_r;

  logic                 mode_ld_s;
  logic                 mode_chg_s;
  logic                 drain_acc_s;
  logic                 inflight_s;
  logic                 unused_tail_s;

  assign act_pipe_s[0]   = in_w;
  assign sgn_pipe_s[0]   = act_mode;
  assign inst_pipe_s[0]  = inst_w;
  assign drain_pipe_s[0] = drain_acc_s;
  assign busy            = busy_r;

  // Activation data leaving the east end has no consumer
  assign unused_tail_s = ^{act_pipe_s[col], sgn_pipe_s[col]};

  genvar j;
  generate
    for (j = 0; j < col; j++) begin : g_tile
      mac_tile_ws_os #(
        .bw      (bw),
        .psum_bw (psum_bw)
      ) u_tile (
        .clk       (clk),
        .reset     (reset),
        .mode_q    (mode_q_r),
        .mode_clr  (mode_chg_s),
        .act_w     (act_pipe_s[j]),
        .act_sgn_w (sgn_pipe_s[j]),
        .inst_w    (inst_pipe_s[j]),
        .drain_w   (drain_pipe_s[j]),
        .in_n      (in_n[psum_bw*j +: psum_bw]),
        .act_e     (act_pipe_s[j+1]),
        .act_sgn_e (sgn_pipe_s[j+1]),
        .inst_e    (inst_pipe_s[j+1]),
        .drain_e   (drain_pipe_s[j+1]),
        .out_s     (out_s[psum_bw*j +: psum_bw]),
        .valid     (valid[j])
      );
    end
  endgenerate

  // Mode-latch qualification, drain acceptance and FSM next state
  always_comb begin
    mode_ld_s   = !busy_r && (inst_w == 2'b00) && !drain;
    mode_chg_s  = mode_ld_s && (mode != mode_q_r);
    drain_acc_s = drain && (mode_q_r == MODE_OS);
    inflight_s  = (|inst_pipe_s[col:1]) || (|drain_pipe_s[col:1]);
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    if (drain_acc_s) begin
      // A fresh drain (re)starts the countdown across the whole row
      state_nxt_s = DRAIN;
      cnt_nxt_s   = CNT_W'(col - 1);
    end else begin
      case (state_r)
        IDLE: begin
          if (inst_w != 2'b00) begin
            state_nxt_s = RUN;
          end else begin
            state_nxt_s = IDLE;
          end
        end
        RUN: begin
          if (!inflight_s && (inst_w == 2'b00)) begin
            state_nxt_s = IDLE;
          end else begin
            state_nxt_s = RUN;
          end
        end
        DRAIN: begin
          if (cnt_r != '0) begin
            cnt_nxt_s = cnt_r - 1'b1;
          end else if (!inflight_s && (inst_w == 2'b00)) begin
            state_nxt_s = IDLE;
          end else begin
            state_nxt_s = DRAIN;
          end
        end
        default: begin
          state_nxt_s = IDLE;
          cnt_nxt_s   = '0;
        end
      endcase
    end
  end

  // FSM, counter, busy and latched mode registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r  <= IDLE;
      cnt_r    <= '0;
      busy_r   <= 1'b0;
      mode_q_r <= MODE_WS;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      busy_r  <= (state_nxt_s != IDLE);
      if (mode_ld_s) begin
        mode_q_r <= mode;
      end else begin
        mode_q_r <= mode_q_r;
      end
    end
  end

endmodule
